// File: rtl/production_pattern_gen.sv
// production_pattern_gen: production-test pattern walker with selectable pattern, pause, restart and sweep counting
module production_pattern_gen #(
  parameter int WIDTH      = 80,
  parameter int ON_CYCLES  = 25000,
  parameter int OFF_CYCLES = 25000,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run_n,
  input  logic [1:0]       Mode,
  input  logic             Restart,
  output logic [WIDTH-1:0] Pat_Out,
  output logic             Led_State,
  output logic             Sweep_Done,
  output logic [CNT_W-1:0] Pass_Count,
  output logic             Busy
);
  localparam int MAX_C = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
  localparam int TW = $clog2(MAX_C + 1);
  localparam int SW = $clog2(WIDTH);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  state_t state;
  logic [1:0] sync;
  logic [1:0] mode_q;
  logic [SW-1:0] step;
  logic [TW-1:0] timer;
  logic run;
  assign run = ~sync[1];
  function automatic logic [WIDTH-1:0] pattern(input logic [1:0] m, input logic [SW-1:0] s);
    logic [WIDTH-1:0] hot;
    logic [WIDTH-1:0] cb;
    hot = WIDTH'(1) << s;
    for (int i = 0; i < WIDTH; i++) cb[i] = i[0] ^ ~s[0];
    return m == 2'd0 ? hot : m == 2'd1 ? ~hot : m == 2'd2 ? cb : '1;
  endfunction
  function automatic logic [WIDTH-1:0] idle_val(input logic [1:0] m);
    return m == 2'd1 ? '1 : '0;
  endfunction
  function automatic logic [SW-1:0] last_step(input logic [1:0] m);
    return m[1] ? (m[0] ? '0 : SW'(1)) : SW'(WIDTH - 1);
  endfunction
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync       <= 2'b11;
      state      <= IDLE;
      mode_q     <= 2'd0;
      step       <= '0;
      timer      <= '0;
      Pat_Out    <= '0;
      Led_State  <= 1'b0;
      Sweep_Done <= 1'b0;
      Pass_Count <= '0;
      Busy       <= 1'b0;
    end else begin
      sync       <= {sync[0], Run_n};
      Sweep_Done <= 1'b0;
      if (Restart) begin
        state   <= IDLE;
        Busy    <= 1'b0;
        step    <= '0;
        timer   <= '0;
        Pat_Out <= idle_val(mode_q);
      end else begin
        case (state)
          IDLE: begin
            step  <= '0;
            timer <= '0;
            if (run) begin
              state   <= ON;
              Busy    <= 1'b1;
              mode_q  <= Mode;
              Pat_Out <= pattern(Mode, '0);
            end else begin
              Pat_Out <= idle_val(mode_q);
            end
          end
          ON: if (run) begin
            if (timer == ON_LAST) begin
              timer   <= '0;
              state   <= OFF;
              Pat_Out <= idle_val(mode_q);
            end else begin
              timer <= timer + TW'(1);
            end
          end
          OFF: if (run) begin
            if (timer == OFF_LAST) begin
              timer <= '0;
              state <= ON;
              if (step == last_step(mode_q)) begin
                Sweep_Done <= 1'b1;
                Led_State  <= ~Led_State;
                if (~&Pass_Count) Pass_Count <= Pass_Count + CNT_W'(1);
                step    <= '0;
                mode_q  <= Mode;
                Pat_Out <= pattern(Mode, '0);
              end else begin
                step    <= step + SW'(1);
                Pat_Out <= pattern(mode_q, step + SW'(1));
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/production_pattern_gen.md
Name: production_pattern_gen

Overview:
- Parametrised successor to the board production-test walker.
- Drives a WIDTH-bit output bus with a selectable test pattern, advancing one step per ON/OFF period while Run_n is held low.
- Counts completed sweeps and toggles a pass LED at each sweep end.
- Sits between the board clock and the shield I/O ports (Duino, TWI and Port0..7 concatenated upstream).

Parameters:
- WIDTH, 80: output bus width, >= 2.
- ON_CYCLES, 25000: clocks the pattern is driven per step (1 ms at 25 MHz), >= 1.
- OFF_CYCLES, 25000: clocks the idle value is driven per step, >= 1.
- CNT_W, 16: width of Pass_Count.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Run_n  in  1  active-low run request (button); asynchronous, synchronised internally.
- Mode  in  2  pattern select: 0 walk-1, 1 walk-0, 2 checkerboard, 3 all-on flash.
- Restart  in  1  synchronous single-cycle pulse; aborts the current sweep.
- Pat_Out  out  WIDTH  test pattern bus, registered.
- Led_State  out  1  toggles at each completed sweep.
- Sweep_Done  out  1  one-cycle pulse at sweep completion.
- Pass_Count  out  CNT_W  completed sweeps, saturating.
- Busy  out  1  high when not in IDLE.

Behaviour:
- Reset (async, active-high): Pat_Out=0, Led_State=0, Sweep_Done=0, Pass_Count=0, Busy=0, state=IDLE, step=0, timer=0, latched mode=0, sync flops=1 (Run_n inactive).
- Run_n passes through a 2-FF synchroniser, giving run = !synced. Latency is 2 clocks from pin to internal run.
- States: IDLE, ON, OFF.
- IDLE:
  - Pat_Out = idle value of the latched mode; step=0.
  - On run=1: latch Mode and go to ON. Pat_Out = pattern(step 0) on that same edge. Busy=1.
- ON:
  - Held for exactly ON_CYCLES clocks, then Pat_Out = idle value and go to OFF.
- OFF:
  - Held for exactly OFF_CYCLES clocks.
  - If step < last: step++, go to ON, Pat_Out = pattern(step+1).
  - If step == last: Sweep_Done=1 for one cycle, Led_State toggles, Pass_Count++ (holds at all-ones), step=0, re-latch Mode, go to ON with the new pattern(0).
- Step period = ON_CYCLES + OFF_CYCLES clocks, exact.
- Patterns (bit 0 = LSB) and sweep length:
  - Mode 0: bit k set, others 0; idle all-0; WIDTH steps.
  - Mode 1: bit k clear, others 1; idle all-1; WIDTH steps.
  - Mode 2: step 0 = ...0101, step 1 = ...1010; idle all-0; 2 steps.
  - Mode 3: all-1; idle all-0; 1 step.
- Mode is sampled only at sweep start. A change mid-sweep has no effect until the next sweep.
- Pause: run=0 in ON/OFF freezes timer, step and Pat_Out (hold, no idle substitution). Busy stays 1. Resume continues from the exact count.
- run=0 in IDLE: remain in IDLE.
- Restart:
  - In any state: next edge gives state=IDLE, step=0, timer=0, Pat_Out=idle value, Busy=0, Sweep_Done=0.
  - Pass_Count and Led_State are preserved.
  - Restart takes priority over sweep completion in the same cycle (no count, no toggle).
  - If run is still 1, ON is re-entered on the following cycle.
- Sweep_Done is never asserted outside the completion cycle and is never asserted while paused.
- Timer width = clog2(max(ON_CYCLES, OFF_CYCLES)+1). Step counter width = clog2(WIDTH).
- Reset mid-sweep: immediate async return to reset values, including Pass_Count.

Test Plan (WIDTH=8, ON_CYCLES=4, OFF_CYCLES=4, CNT_W=4):
- Reset, Run_n=0, Mode=0 -> after 2-cycle sync, Pat_Out=0x01 for 4 clks, 0x00 for 4 clks, then 0x02 ... 0x80. After 64 clks Sweep_Done pulses once, Led_State=1, Pass_Count=1, Pat_Out returns to 0x01.
- Mode=1 -> Pat_Out sequence 0xFE, 0xFF, 0xFD, 0xFF, ..., 0x7F, idle 0xFF. Mode=2 -> 0x55, 0x00, 0xAA, 0x00, Sweep_Done every 16 clks. Mode=3 -> 0xFF / 0x00, Sweep_Done every 8 clks.
- Run_n released after 2 ON clocks at step 3 (0x08) for 10 clks -> Pat_Out holds 0x08, no timer/step change. On re-press (plus 2-cycle sync) exactly 2 more ON clocks at 0x08 follow.
- Mode switched 0->2 at step 4 -> walk-1 completes to 0x80, then next sweep starts at 0x55.
- Restart pulsed in the same cycle as the final OFF count -> no Sweep_Done, Pass_Count unchanged, Pat_Out=0x00 and Busy=0 for 1 clk, then 0x01.
- 16 Mode-3 sweeps -> Pass_Count saturates at 0xF, Led_State keeps toggling. Async Reset mid-ON -> all outputs 0 without waiting for a clock edge.
